// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: per-stage stall vector, flush and PC
// redirect for branches, traps and mret, plus a sticky stall watchdog.
module pipe_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        branch_redirect_i,
  input  logic [31:0] branch_target_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vector_i,
  input  logic        mret_req_i,
  input  logic [31:0] mepc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        stall_timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    TRAP_WAIT,
    FLUSH
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STALL_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [7:0]  count_q, count_d;
  logic [5:0]  stage_stall;

  // Highest requesting stage wins: it and every stage upstream of it hold.
  always_comb begin
    stage_stall = '0;
    if (stallreq_mem_i)      stage_stall = 6'b011111;
    else if (stallreq_ex_i)  stage_stall = 6'b001111;
    else if (stallreq_id_i)  stage_stall = 6'b000111;
    else if (stallreq_if_i)  stage_stall = 6'b000011;
  end

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    stall_o       = '0;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    unique case (state_q)
      IDLE: begin
        if (trap_req_i || mret_req_i) begin
          tgt_d   = trap_req_i ? trap_vector_i : mepc_i;
          stall_o = 6'b011111;
          state_d = stallreq_mem_i ? TRAP_WAIT : FLUSH;
        end else if (branch_redirect_i && !stallreq_ex_i && !stallreq_mem_i) begin
          flush_o       = 1'b1;
          redirect_o    = 1'b1;
          redirect_pc_o = branch_target_i;
        end else begin
          stall_o = stage_stall;
        end
      end
      TRAP_WAIT: begin
        stall_o = 6'b011111;
        if (!stallreq_mem_i) state_d = FLUSH;
      end
      FLUSH: begin
        flush_o       = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = tgt_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset masks every strobe so nothing escapes while the FSM is being cleared.
    if (n_rst_i) begin
      stall_o       = '0;
      flush_o       = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
    end
  end

  always_comb begin
    count_d = '0;
    if (stall_o != '0) count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (n_rst_i) begin
      state_q         <= IDLE;
      tgt_q           <= '0;
      count_q         <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      count_q <= count_d;
      if ((stall_o != '0) && (count_d >= LIMIT)) stall_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic        br;
  logic [31:0] bt;
  logic        trap;
  logic [31:0] tvec;
  logic        mret;
  logic [31:0] mepc;
  logic [5:0]  stall;
  logic        flush, redir, tmo;
  logic [31:0] rpc;

  typedef struct {
    string       name;
    logic [40:0] exp;
  } item_t;

  item_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    done     = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_TIMEOUT(4)) dut (
    .clk_i(clk),
    .n_rst_i(n_rst),
    .stallreq_if_i(s_if),
    .stallreq_id_i(s_id),
    .stallreq_ex_i(s_ex),
    .stallreq_mem_i(s_mem),
    .branch_redirect_i(br),
    .branch_target_i(bt),
    .trap_req_i(trap),
    .trap_vector_i(tvec),
    .mret_req_i(mret),
    .mepc_i(mepc),
    .stall_o(stall),
    .flush_o(flush),
    .redirect_o(redir),
    .redirect_pc_o(rpc),
    .stall_timeout_o(tmo)
  );

  task automatic drive(input logic r, input logic i_f, input logic i_d, input logic e,
                       input logic m, input logic b, input logic [31:0] t,
                       input logic tr, input logic [31:0] tv,
                       input logic mr, input logic [31:0] mp);
    n_rst = r; s_if = i_f; s_id = i_d; s_ex = e; s_mem = m;
    br = b; bt = t; trap = tr; tvec = tv; mret = mr; mepc = mp;
  endtask

  task automatic cyc(input string name, input logic [5:0] st, input logic fl,
                     input logic rd, input logic [31:0] pc, input logic to);
    item_t it;
    it.name = name;
    it.exp  = {st, fl, rd, pc, to};
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin : monitor
    item_t       it;
    logic [40:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        it  = q.pop_front();
        act = {stall, flush, redir, rpc, tmo};
        n_checks++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got stall=%b flush=%b redir=%b pc=%h tmo=%b, want stall=%b flush=%b redir=%b pc=%h tmo=%b",
                   it.name, act[40:35], act[34], act[33], act[32:1], act[0],
                   it.exp[40:35], it.exp[34], it.exp[33], it.exp[32:1], it.exp[0]);
        end
      end
    end
  end

  initial begin : timeout_guard
    #200000;
    $display("FAIL sim_timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    drive(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 1, 32'h1234, 1, 32'h5678);
    @(posedge clk);
    #1;
    cyc("rst_gated", 6'b0, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc("rst_idle", 6'b0, 0, 0, 32'h0, 0);

    drive(0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc("id_stall", 6'b000111, 0, 0, 32'h0, 0);
    idle_in();
    cyc("id_release", 6'b0, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc("if_stall", 6'b000011, 0, 0, 32'h0, 0);
    drive(0, 1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc("ex_prio", 6'b001111, 0, 0, 32'h0, 0);
    drive(0, 1, 1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc("mem_prio", 6'b011111, 0, 0, 32'h0, 0);
    idle_in();
    cyc("stall_clear", 6'b0, 0, 0, 32'h0, 0);

    drive(0, 0, 0, 0, 0, 1, 32'h8000_0040, 0, 32'h0, 0, 32'h0);
    cyc("branch", 6'b0, 1, 1, 32'h8000_0040, 0);
    drive(0, 0, 0, 1, 0, 1, 32'h8000_0080, 0, 32'h0, 0, 32'h0);
    cyc("branch_ex_hold", 6'b001111, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h8000_0080, 0, 32'h0, 0, 32'h0);
    cyc("branch_mem_hold", 6'b011111, 0, 0, 32'h0, 0);
    idle_in();
    cyc("post_branch", 6'b0, 0, 0, 32'h0, 0);

    drive(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0000_0100, 0, 32'h0000_0200);
    cyc("trap_accept", 6'b011111, 0, 0, 32'h0, 0);
    drive(0, 1, 1, 1, 1, 1, 32'h0000_0999, 1, 32'h0000_0300, 0, 32'h0);
    cyc("trap_flush", 6'b0, 1, 1, 32'h0000_0100, 0);
    idle_in();
    cyc("trap_done", 6'b0, 0, 0, 32'h0, 0);

    drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0000_0200);
    cyc("mret_accept", 6'b011111, 0, 0, 32'h0, 0);
    idle_in();
    cyc("mret_flush", 6'b0, 1, 1, 32'h0000_0200, 0);

    drive(0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h0000_0400, 1, 32'h0000_0500);
    cyc("prio_accept", 6'b011111, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h0000_0999, 0, 32'h0, 0, 32'h0);
    cyc("prio_wait1", 6'b011111, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h0000_0777, 0, 32'h0);
    cyc("prio_wait2", 6'b011111, 0, 0, 32'h0, 0);
    idle_in();
    cyc("prio_wait3", 6'b011111, 0, 0, 32'h0, 0);
    // four consecutive stalled edges with STALL_TIMEOUT=4 trips the watchdog
    cyc("prio_flush", 6'b0, 1, 1, 32'h0000_0400, 1);
    cyc("prio_idle", 6'b0, 0, 0, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc("rst_sticky", 6'b0, 0, 0, 32'h0, 1);
    idle_in();
    cyc("rst_clears_tmo", 6'b0, 0, 0, 32'h0, 0);

    drive(0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h0000_0600, 0, 32'h0);
    cyc("abort_accept", 6'b011111, 0, 0, 32'h0, 0);
    cyc("abort_wait", 6'b011111, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc("abort_rst", 6'b0, 0, 0, 32'h0, 0);
    idle_in();
    cyc("abort_no_flush", 6'b0, 0, 0, 32'h0, 0);
    cyc("abort_idle", 6'b0, 0, 0, 32'h0, 0);

    drive(0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 6; i++) cyc("wdog_ex", 6'b001111, 0, 0, 32'h0, (i >= 4));
    idle_in();
    cyc("wdog_hold1", 6'b0, 0, 0, 32'h0, 1);
    cyc("wdog_hold2", 6'b0, 0, 0, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc("wdog_rst", 6'b0, 0, 0, 32'h0, 1);
    idle_in();
    cyc("wdog_cleared", 6'b0, 0, 0, 32'h0, 0);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
